// File: rtl/onc_pipe_ctl.sv
// Pipeline control for the ONC-16 core.
// Tracks the D slot plus every post-decode slot, stalls decode on RAW
// hazards, kills younger work on a taken branch, and counts stall and
// flush cycles. The register file has no bypass, so a source must wait
// until its writer has retired from the last slot.
module onc_pipe_ctl #(
    parameter int STAGES    = 2,
    parameter int RF_ADDR_W = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clock,
    input  logic                 n_rst,
    input  logic                 en_i,
    input  logic                 f_valid_i,
    input  logic [RF_ADDR_W-1:0] d_rs1_addr_i,
    input  logic [RF_ADDR_W-1:0] d_rs2_addr_i,
    input  logic                 d_rs1_use_i,
    input  logic                 d_rs2_use_i,
    input  logic [RF_ADDR_W-1:0] d_rd_addr_i,
    input  logic                 d_rd_we_i,
    input  logic                 br_taken_i,
    input  logic                 cnt_clr_i,
    output logic                 pc_en_o,
    output logic                 fd_en_o,
    output logic                 d_issue_o,
    output logic                 d_valid_o,
    output logic [STAGES-1:0]    stage_valid_o,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic                 wb_we_o,
    output logic [RF_ADDR_W-1:0] wb_addr_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                 d_valid_q, d_valid_d;
    logic [STAGES-1:0]    slot_valid_q, slot_valid_d;
    logic [STAGES-1:0]    slot_we_q, slot_we_d;
    logic [RF_ADDR_W-1:0] slot_rd_q [STAGES];
    logic [RF_ADDR_W-1:0] slot_rd_d [STAGES];
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic rs1_hit, rs2_hit;
    logic hazard, flush, stall;

    // Look up each decode source against every in-flight writer.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (slot_valid_q[i] && slot_we_q[i]) begin
                if (slot_rd_q[i] == d_rs1_addr_i) rs1_hit = 1'b1;
                if (slot_rd_q[i] == d_rs2_addr_i) rs2_hit = 1'b1;
            end
        end
    end

    assign hazard = d_valid_q && ((d_rs1_use_i && rs1_hit) || (d_rs2_use_i && rs2_hit));
    // A branch only counts when slot 1 really holds an instruction.
    assign flush  = en_i && br_taken_i && slot_valid_q[0];
    assign stall  = en_i && hazard && !flush;

    assign pc_en_o       = en_i && !stall;
    assign fd_en_o       = en_i && !stall;
    assign d_issue_o     = en_i && d_valid_q && !stall && !flush;
    assign stall_o       = stall;
    assign flush_o       = flush;
    assign d_valid_o     = d_valid_q;
    assign stage_valid_o = slot_valid_q;
    assign wb_we_o       = slot_valid_q[STAGES-1] && slot_we_q[STAGES-1];
    assign wb_addr_o     = slot_rd_q[STAGES-1];
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

    // Next pipeline occupancy: slots shift every enabled cycle; slot 1 takes
    // a bubble on stall or flush, otherwise the decode instruction.
    always_comb begin
        d_valid_d    = d_valid_q;
        slot_valid_d = slot_valid_q;
        slot_we_d    = slot_we_q;
        slot_rd_d    = slot_rd_q;
        if (en_i) begin
            for (int i = 1; i < STAGES; i++) begin
                slot_valid_d[i] = slot_valid_q[i-1];
                slot_we_d[i]    = slot_we_q[i-1];
                slot_rd_d[i]    = slot_rd_q[i-1];
            end
            if (stall || flush) begin
                slot_valid_d[0] = 1'b0;
                slot_we_d[0]    = 1'b0;
                slot_rd_d[0]    = '0;
            end else begin
                slot_valid_d[0] = d_valid_q;
                slot_we_d[0]    = d_rd_we_i;
                slot_rd_d[0]    = d_rd_addr_i;
            end
            if (flush) begin
                d_valid_d = 1'b0;
            end else if (!stall) begin
                d_valid_d = f_valid_i;
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            d_valid_q    <= 1'b0;
            slot_valid_q <= '0;
            slot_we_q    <= '0;
            for (int i = 0; i < STAGES; i++) slot_rd_q[i] <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            d_valid_q    <= d_valid_d;
            slot_valid_q <= slot_valid_d;
            slot_we_q    <= slot_we_d;
            slot_rd_q    <= slot_rd_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_onc_pipe_ctl.sv
// Bench for onc_pipe_ctl: directed instruction sequences, a queue-based
// pipeline model checked every cycle, and literal expectations at key points.
// A second instance with 2-bit counters shares the stimulus to show saturation.
module tb_onc_pipe_ctl;

    localparam int S = 2;

    logic clock = 1'b0;
    logic n_rst = 1'b0;
    logic en = 1'b1, fv = 1'b1, u1 = 1'b0, u2 = 1'b0, we = 1'b0, br = 1'b0, clr = 1'b0;
    logic [2:0] rs1 = '0, rs2 = '0, rd = '0;

    logic        pc_en, fd_en, iss, dv, st, fl, wbwe;
    logic [1:0]  sv;
    logic [2:0]  wba;
    logic [15:0] scnt, fcnt;

    logic        pc_en2, fd_en2, iss2, dv2, st2, fl2, wbwe2;
    logic [1:0]  sv2;
    logic [2:0]  wba2;
    logic [1:0]  scnt2, fcnt2;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    onc_pipe_ctl #(.STAGES(S), .RF_ADDR_W(3), .CNT_W(16)) dut (
        .clock(clock), .n_rst(n_rst), .en_i(en), .f_valid_i(fv),
        .d_rs1_addr_i(rs1), .d_rs2_addr_i(rs2), .d_rs1_use_i(u1), .d_rs2_use_i(u2),
        .d_rd_addr_i(rd), .d_rd_we_i(we), .br_taken_i(br), .cnt_clr_i(clr),
        .pc_en_o(pc_en), .fd_en_o(fd_en), .d_issue_o(iss), .d_valid_o(dv),
        .stage_valid_o(sv), .stall_o(st), .flush_o(fl), .wb_we_o(wbwe),
        .wb_addr_o(wba), .stall_cnt_o(scnt), .flush_cnt_o(fcnt));

    onc_pipe_ctl #(.STAGES(S), .RF_ADDR_W(3), .CNT_W(2)) dut2 (
        .clock(clock), .n_rst(n_rst), .en_i(en), .f_valid_i(fv),
        .d_rs1_addr_i(rs1), .d_rs2_addr_i(rs2), .d_rs1_use_i(u1), .d_rs2_use_i(u2),
        .d_rd_addr_i(rd), .d_rd_we_i(we), .br_taken_i(br), .cnt_clr_i(clr),
        .pc_en_o(pc_en2), .fd_en_o(fd_en2), .d_issue_o(iss2), .d_valid_o(dv2),
        .stage_valid_o(sv2), .stall_o(st2), .flush_o(fl2), .wb_we_o(wbwe2),
        .wb_addr_o(wba2), .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { bit v; bit we; int rd; } slot_t;
    slot_t pipe[$];
    slot_t pipe_n[$];
    bit m_dv = 0, m_dv_n = 0;
    int m_sc = 0, m_fc = 0, m_sc2 = 0, m_fc2 = 0;
    int m_sc_n = 0, m_fc_n = 0, m_sc2_n = 0, m_fc2_n = 0;

    function automatic bit pending(input int a);
        foreach (pipe[i]) if (pipe[i].v && pipe[i].we && pipe[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int bump(input int c, input bit inc, input bit clear, input int mx);
        if (clear) return 0;
        if (inc && c < mx) return c + 1;
        return c;
    endfunction

    always @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            pipe = {};
            for (int i = 0; i < S; i++) pipe.push_back('{v: 1'b0, we: 1'b0, rd: 0});
            m_dv = 1'b0;
            m_sc = 0; m_fc = 0; m_sc2 = 0; m_fc2 = 0;
        end else begin
            pipe = pipe_n;
            m_dv = m_dv_n;
            m_sc = m_sc_n; m_fc = m_fc_n; m_sc2 = m_sc2_n; m_fc2 = m_fc2_n;
        end
    end

    always @(negedge clock) begin
        bit e_fl, e_hz, e_st, e_wbwe;
        int e_sv;
        slot_t nw;
        e_fl = en && br && pipe[0].v;
        e_hz = m_dv && ((u1 && pending(int'(rs1))) || (u2 && pending(int'(rs2))));
        e_st = en && e_hz && !e_fl;
        e_sv = 0;
        foreach (pipe[i]) if (pipe[i].v) e_sv += (1 << i);
        e_wbwe = pipe[S-1].v && pipe[S-1].we;

        chk("m_pc_en", pc_en, en && !e_st);
        chk("m_fd_en", fd_en, en && !e_st);
        chk("m_d_issue", iss, en && m_dv && !e_st && !e_fl);
        chk("m_d_valid", dv, m_dv);
        chk("m_stage_valid", sv, e_sv);
        chk("m_stall", st, e_st);
        chk("m_flush", fl, e_fl);
        chk("m_wb_we", wbwe, e_wbwe);
        if (e_wbwe) chk("m_wb_addr", wba, pipe[S-1].rd);
        chk("m_stall_cnt", scnt, m_sc);
        chk("m_flush_cnt", fcnt, m_fc);
        chk("m_stall2", st2, e_st);
        chk("m_stall_cnt2", scnt2, m_sc2);
        chk("m_flush_cnt2", fcnt2, m_fc2);

        pipe_n = pipe;
        m_dv_n = m_dv;
        if (en) begin
            nw.v  = (e_st || e_fl) ? 1'b0 : m_dv;
            nw.we = we;
            nw.rd = int'(rd);
            pipe_n.push_front(nw);
            void'(pipe_n.pop_back());
            m_dv_n = e_fl ? 1'b0 : (e_st ? m_dv : fv);
        end
        m_sc_n  = bump(m_sc,  e_st, clr, 65535);
        m_fc_n  = bump(m_fc,  e_fl, clr, 65535);
        m_sc2_n = bump(m_sc2, e_st, clr, 3);
        m_fc2_n = bump(m_fc2, e_fl, clr, 3);
    end

    // ---------------- stimulus ----------------
    // Apply one cycle of inputs just after the rising edge, return at the
    // falling edge so literal checks see settled outputs.
    task automatic step(input int e, input int f, input int a1, input int s1,
                        input int a2, input int s2, input int d, input int w,
                        input int b, input int c);
        @(posedge clock);
        #1;
        en = e[0]; fv = f[0]; rs1 = a1[2:0]; u1 = s1[0]; rs2 = a2[2:0]; u2 = s2[0];
        rd = d[2:0]; we = w[0]; br = b[0]; clr = c[0];
        @(negedge clock);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_pc_en", pc_en, 1);
        chk("rst_stall", st, 0);
        chk("rst_d_issue", iss, 0);
        chk("rst_stage_valid", sv, 0);
        @(posedge clock);
        #1 n_rst = 1'b1;

        // writer r1 then dependent reader: two stall cycles
        step(1,1, 0,0,0,0, 1,1, 0,0);
        chk("A_d_valid", dv, 1); chk("A_stall", st, 0); chk("A_pc_en", pc_en, 1);
        chk("A_stall_cnt", scnt, 0); chk("A_issue", iss, 1);
        step(1,1, 1,1,0,0, 2,0, 0,0);
        chk("B_stall", st, 1); chk("B_pc_en", pc_en, 0); chk("B_issue", iss, 0);
        chk("B_stage_valid", sv, 1);
        step(1,1, 1,1,0,0, 2,0, 0,0);
        chk("C_stall", st, 1); chk("C_wb_we", wbwe, 1); chk("C_wb_addr", wba, 1);
        step(1,1, 1,1,0,0, 2,0, 0,0);
        chk("D_stall", st, 0); chk("D_issue", iss, 1); chk("D_stall_cnt", scnt, 2);
        chk("D_stall_cnt2", scnt2, 2);

        // unused source address matches a writer: no stall
        step(1,1, 0,0,0,0, 1,1, 0,0);
        chk("E_issue", iss, 1);
        step(1,1, 1,0,0,0, 3,1, 0,0);
        chk("F_stall", st, 0); chk("F_issue", iss, 1);
        step(1,1, 0,0,4,1, 7,0, 0,0);
        chk("G_issue", iss, 1);
        // dependency at distance 2 stalls one cycle
        step(1,1, 3,1,0,0, 0,0, 0,0);
        chk("G2_stall", st, 1);
        step(1,1, 3,1,0,0, 0,0, 0,0);
        chk("G3_stall", st, 0); chk("G3_stall_cnt", scnt, 3);

        // branch flush overrides a hazard
        step(1,1, 0,0,0,0, 5,1, 0,0);
        step(1,1, 5,1,0,0, 0,0, 1,0);
        chk("I_flush", fl, 1); chk("I_stall", st, 0); chk("I_pc_en", pc_en, 1);
        chk("I_fd_en", fd_en, 1); chk("I_issue", iss, 0);
        step(1,1, 5,1,0,0, 0,0, 1,0);
        chk("J_d_valid", dv, 0); chk("J_sv0", sv[0], 0); chk("J_flush", fl, 0);
        chk("J_flush_cnt", fcnt, 1);
        step(1,1, 0,0,0,0, 6,1, 0,0);
        chk("K_flush_cnt", fcnt, 1); chk("K_issue", iss, 1);

        // freeze in the middle of a stall
        step(1,1, 0,0,6,1, 0,0, 0,0);
        chk("L_stall", st, 1);
        for (int k = 0; k < 5; k++) begin
            step(0,1, 0,0,6,1, 0,0, 0,0);
            chk("M_stall", st, 0); chk("M_pc_en", pc_en, 0); chk("M_fd_en", fd_en, 0);
            chk("M_stage_valid", sv, 2); chk("M_d_valid", dv, 1);
            chk("M_stall_cnt", scnt, 4); chk("M_stall_cnt2", scnt2, 3);
        end
        step(1,1, 0,0,6,1, 0,0, 0,0);
        chk("N_stall", st, 1);
        step(1,1, 0,0,6,1, 0,0, 0,0);
        chk("O_stall", st, 0); chk("O_issue", iss, 1); chk("O_stall_cnt", scnt, 5);
        chk("O_stall_cnt2", scnt2, 3);

        // clear while frozen, then six stall cycles saturate the 2-bit counter
        step(0,1, 0,0,0,0, 0,0, 0,1);
        for (int n = 0; n < 3; n++) begin
            step(1,1, 0,0,0,0, n+1,1, 0,0);
            if (n == 0) begin
                chk("Q_stall_cnt", scnt, 0); chk("Q_flush_cnt", fcnt, 0);
                chk("Q_stall_cnt2", scnt2, 0);
            end
            step(1,1, n+1,1,0,0, 0,0, 0,0);
            chk("R_stall_a", st, 1);
            step(1,1, n+1,1,0,0, 0,0, 0,0);
            chk("R_stall_b", st, 1);
            step(1,1, n+1,1,0,0, 0,0, 0,0);
            chk("R_issue", iss, 1);
        end
        chk("R_stall_cnt", scnt, 6); chk("R_stall_cnt2", scnt2, 3);

        // clear beats a same-cycle increment
        step(1,1, 0,0,0,0, 1,1, 0,0);
        step(1,1, 1,1,0,0, 0,0, 0,1);
        chk("T_stall", st, 1);
        step(1,1, 1,1,0,0, 0,0, 0,0);
        chk("U_stall_cnt", scnt, 0); chk("U_stall", st, 1);
        step(1,1, 1,1,0,0, 0,0, 0,0);
        chk("V_stall_cnt", scnt, 1); chk("V_issue", iss, 1);

        // reset in the middle of a stall
        step(1,1, 0,0,0,0, 2,1, 0,0);
        step(1,1, 2,1,0,0, 0,0, 0,0);
        chk("X_stall", st, 1);
        #2 n_rst = 1'b0;
        @(negedge clock);
        chk("Y_stage_valid", sv, 0); chk("Y_d_valid", dv, 0); chk("Y_stall", st, 0);
        chk("Y_stall_cnt", scnt, 0);
        @(posedge clock);
        #1 n_rst = 1'b1;
        step(1,1, 2,1,0,0, 0,0, 0,0);
        chk("Z_stall", st, 0); chk("Z_issue", iss, 1); chk("Z_d_valid", dv, 1);

        step(1,0, 0,0,0,0, 0,0, 0,0);
        step(1,0, 0,0,0,0, 0,0, 0,0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onc_pipe_ctl.md
# onc_pipe_ctl

Parametrised pipeline control unit for the next-generation ONC-16 pipelined core. It tracks the valid bit and write-back destination of every in-flight instruction, detects read-after-write hazards at decode, and generates stall (interlock) and branch-flush control. It drives the PC, F/D and D/E register enables that the core top currently derives directly from `en`. It also keeps saturating stall and flush event counters for performance measurement.

## Interface
- STAGES, 2: number of post-decode stages holding a destination (slot 1 = E … slot STAGES = W); legal range 1..8
- RF_ADDR_W, 3: register-file address width
- CNT_W, 16: event counter width
- clock  in  1  rising-edge clock
- n_rst  in  1  reset n_rst, asynchronous, active-low; clock clock
- en  in  1  global run enable; 0 freezes all state
- f_valid  in  1  fetch stage presents a valid instruction this cycle
- d_rs1_addr / d_rs2_addr  in  RF_ADDR_W  decode source addresses
- d_rs1_use / d_rs2_use  in  1  decode instruction reads the source
- d_rd_addr  in  RF_ADDR_W  decode destination address
- d_rd_we  in  1  decode instruction writes the register file
- br_taken  in  1  branch resolved taken in slot 1 (E)
- cnt_clr  in  1  synchronous clear of both counters
- pc_en  out  1  PC advances or loads its target
- fd_en  out  1  F/D register loads
- d_issue  out  1  decode instruction moves into slot 1
- d_valid  out  1  D slot holds a valid instruction
- stage_valid  out  STAGES  valid bits, bit i-1 = slot i
- stall  out  1  RAW interlock active this cycle
- flush  out  1  taken branch kills younger instructions
- wb_we  out  1  slot STAGES is valid and writes
- wb_addr  out  RF_ADDR_W  destination of slot STAGES
- stall_cnt / flush_cnt  out  CNT_W  saturating event counts

## Operation
- State: the D valid bit, plus (valid, rd, we) for each of slots 1..STAGES.
- The register file has no internal bypass. A slot-STAGES write becomes readable only after the clock edge that ends that slot.
- A slot match for source rsN is: slot valid && slot we && slot rd == d_rsN_addr.
- hazard = d_valid && ((d_rs1_use && any slot matches rs1) || (d_rs2_use && any slot matches rs2)). Every address is checked; there is no hardwired zero register.
- flush = en && br_taken && stage_valid[0]. A br_taken input arriving while slot 1 is invalid is ignored.
- stall = en && hazard && !flush. Flush has priority over stall.
- When en=1, the next-state rule for each case is:
  - Flush: the branch in slot 1 advances normally. Slot 1 receives a bubble. The D slot loads invalid, so the fetched instruction is discarded. pc_en=1 so the PC loads the branch target. fd_en=1, d_issue=0.
  - Stall: the D slot holds its contents. pc_en=0, fd_en=0, d_issue=0. Slot 1 receives a bubble. Slots 2..STAGES advance.
  - Normal: slot 1 receives (d_valid, d_rd_addr, d_rd_we). D loads f_valid. pc_en=fd_en=1, d_issue=d_valid.
- When en=0: no state changes and counters hold. pc_en, fd_en, d_issue, stall and flush are all 0.
- Each slot shifts into the next, and slot STAGES retires.
- Counters: each cycle stall=1 adds 1 to stall_cnt, and each cycle flush=1 adds 1 to flush_cnt. Both saturate at 2^CNT_W−1.
- cnt_clr zeroes both counters and overrides an increment in the same cycle. It acts even when en=0.

## Timing
- Reset values: all valid bits 0, d_valid=0, stage_valid=0, wb_we=0, wb_addr=0, stall_cnt=0, flush_cnt=0.
- Outputs derived from the inputs during and after reset: stall=0, flush=0, pc_en=fd_en=en, d_issue=0.
- The paths from d_*, br_taken and en to stall, flush, pc_en, fd_en and d_issue are combinational, with a same-cycle response.
- stage_valid, d_valid, wb_we, wb_addr and the counters are registered outputs.
- A back-to-back dependent instruction stalls exactly STAGES cycles. A dependency at distance k (1≤k≤STAGES) stalls STAGES−k+1 cycles.
- A taken branch costs 2 bubbles: the killed D instruction and the killed fetch slot.
- Reset asserted mid-operation clears all in-flight state on the same edge. The first instruction fetched after release has no hazard.

## Test plan
- Reset with en=1 and f_valid=1: the cycle after release d_valid=1, stall=0, pc_en=1, stall_cnt=0.
- STAGES=2, writer r1 (we=1) then reader rs1=r1 (use=1): stall=1 for exactly 2 cycles, then d_issue=1, stall_cnt=2, wb_addr=1 with wb_we=1 in the cycle before issue.
- Writer r1 then reader with d_rs1_use=0 and d_rs1_addr=1: no stall, and a new instruction issues every cycle.
- br_taken=1 with slot 1 valid while D holds a hazard: flush=1, stall=0, d_valid=0 and stage_valid[0]=0 the next cycle, flush_cnt=1.
- Hold en=0 for 5 cycles in the middle of a stall: all valid bits and stall_cnt unchanged, pc_en=0. After en returns to 1 the stall resumes with its remaining count.
- CNT_W=2 with 5 consecutive stall cycles: stall_cnt saturates at 3. Asserting cnt_clr gives 0 the next cycle.
